// File: rtl/wb_regfile_writeback_pkg.sv
// Shared definitions for the write-back stage: source-select encodings and width defaults.
package wb_regfile_writeback_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Write-back source select carried down the pipe as MemtoReg.
    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_NPC = 2'b10,
        MTR_EXT = 2'b11
    } mtr_e;

endpackage

// File: rtl/wb_regfile_writeback_if.sv
// MEM/WB pipeline-register fields into the write-back stage, plus the committed
// write published back to the forwarding unit.
interface wb_regfile_writeback_if #(
    parameter int DATA_W = wb_regfile_writeback_pkg::DATA_W_DEF,
    parameter int ADDR_W = wb_regfile_writeback_pkg::ADDR_W_DEF
);
    logic              wb_valid_i;
    logic [1:0]        mem_to_reg_wb_i;
    logic              reg_write_wb_i;
    logic              first_wb_i;
    logic [DATA_W-1:0] npc_wb_i;
    logic [DATA_W-1:0] md_wb_i;
    logic [DATA_W-1:0] aluout_wb_i;
    logic [DATA_W-1:0] ext_wb_i;
    logic [DATA_W-1:0] rd_wb_i;
    logic [DATA_W-1:0] cd_wb_i;

    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;

    // Pipeline side: drives the WB fields, observes the commit.
    modport master (
        output wb_valid_i, mem_to_reg_wb_i, reg_write_wb_i, first_wb_i,
               npc_wb_i, md_wb_i, aluout_wb_i, ext_wb_i, rd_wb_i, cd_wb_i,
        input  wb_we_o, wb_waddr_o, wb_wdata_o
    );

    // Write-back stage side.
    modport slave (
        input  wb_valid_i, mem_to_reg_wb_i, reg_write_wb_i, first_wb_i,
               npc_wb_i, md_wb_i, aluout_wb_i, ext_wb_i, rd_wb_i, cd_wb_i,
        output wb_we_o, wb_waddr_o, wb_wdata_o
    );

endinterface

// File: rtl/wb_regfile_writeback_gpr_2r1w.sv
// General register storage: one write port, two ID read ports and a debug read port.
// Reads return stored contents only; bypass and $0 handling live in the top.
module gpr_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] dbg_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;

    // Next array contents: hold, or overwrite the addressed entry.
    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    // Array register with asynchronous clear of every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign rd1_o = mem_q[ra1_i];
    assign rd2_o = mem_q[ra2_i];
    assign dbg_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/wb_regfile_writeback.sv
// Write-back stage: picks the write-back value, qualifies the GPR write, serves the
// ID read ports with same-cycle bypass and counts retired instructions.
module wb_regfile_writeback
    import wb_regfile_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_regfile_writeback_if.slave   wb,
    input  logic [ADDR_W-1:0]       ra1_i,
    input  logic [ADDR_W-1:0]       ra2_i,
    output logic [DATA_W-1:0]       rd1_o,
    output logic [DATA_W-1:0]       rd2_o,
    input  logic [ADDR_W-1:0]       dbg_addr_i,
    output logic [DATA_W-1:0]       dbg_data_o,
    output logic [CNT_W-1:0]        instret_o
);

    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [DATA_W-1:0] arr_rd1, arr_rd2;
    logic [CNT_W-1:0]  instret_q, instret_d;

    // Upper destination bits carry no meaning; only the low ADDR_W select a register.
    logic unused_rd_hi;
    assign unused_rd_hi = ^wb.rd_wb_i[DATA_W-1:ADDR_W];

    // Write-back source select; a CP0 read overrides MemtoReg.
    always_comb begin
        wdata = wb.aluout_wb_i;
        if (wb.first_wb_i) begin
            wdata = wb.cd_wb_i;
        end else begin
            case (mtr_e'(wb.mem_to_reg_wb_i))
                MTR_ALU: wdata = wb.aluout_wb_i;
                MTR_MEM: wdata = wb.md_wb_i;
                MTR_NPC: wdata = wb.npc_wb_i;
                MTR_EXT: wdata = wb.ext_wb_i;
                default: wdata = wb.aluout_wb_i;
            endcase
        end
    end

    // $0 writes never count as a write, so the array and forwarding never see them.
    assign waddr = wb.rd_wb_i[ADDR_W-1:0];
    assign we    = wb.wb_valid_i & wb.reg_write_wb_i & (waddr != '0);

    // Address/data follow the inputs even when idle; consumers gate on wb_we_o.
    assign wb.wb_we_o    = we;
    assign wb.wb_waddr_o = waddr;
    assign wb.wb_wdata_o = wdata;

    gpr_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .ra1_i      (ra1_i),
        .ra2_i      (ra2_i),
        .dbg_addr_i (dbg_addr_i),
        .rd1_o      (arr_rd1),
        .rd2_o      (arr_rd2),
        .dbg_o      (dbg_data_o)
    );

    // ID read ports: $0 and reset read zero, a same-cycle write to the address wins over the array.
    always_comb begin
        rd1_o = arr_rd1;
        rd2_o = arr_rd2;
        if (rst || ra1_i == '0)           rd1_o = '0;
        else if (we && waddr == ra1_i)    rd1_o = wdata;
        if (rst || ra2_i == '0)           rd2_o = '0;
        else if (we && waddr == ra2_i)    rd2_o = wdata;
    end

    // Retired count advances on every real instruction, written or not; wraps naturally.
    always_comb begin
        instret_d = instret_q;
        if (wb.wb_valid_i) instret_d = instret_q + 1'b1;
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= '0;
        else     instret_q <= instret_d;
    end

    assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
module tb_wb_regfile_writeback;
    import wb_regfile_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, dbg_addr;
    logic [31:0] rd1, rd2, dbg_data, instret;
    logic [4:0]  ra1_4, ra2_4, dbg_addr_4;
    logic [31:0] rd1_4, rd2_4, dbg_data_4;
    logic [3:0]  instret_4;

    int checks = 0;
    int errors = 0;

    wb_regfile_writeback_if bus ();
    wb_regfile_writeback_if bus4 ();

    always #5 clk = ~clk;

    wb_regfile_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (bus.slave),
        .ra1_i      (ra1),
        .ra2_i      (ra2),
        .rd1_o      (rd1),
        .rd2_o      (rd2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .instret_o  (instret)
    );

    wb_regfile_writeback #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .wb         (bus4.slave),
        .ra1_i      (ra1_4),
        .ra2_i      (ra2_4),
        .rd1_o      (rd1_4),
        .rd2_o      (rd2_4),
        .dbg_addr_i (dbg_addr_4),
        .dbg_data_o (dbg_data_4),
        .instret_o  (instret_4)
    );

    task automatic set_idle();
        bus.wb_valid_i = 0; bus.mem_to_reg_wb_i = 2'b00; bus.reg_write_wb_i = 0;
        bus.first_wb_i = 0; bus.npc_wb_i = 0; bus.md_wb_i = 0; bus.aluout_wb_i = 0;
        bus.ext_wb_i = 0; bus.rd_wb_i = 0; bus.cd_wb_i = 0;
        bus4.wb_valid_i = 0; bus4.mem_to_reg_wb_i = 2'b00; bus4.reg_write_wb_i = 0;
        bus4.first_wb_i = 0; bus4.npc_wb_i = 0; bus4.md_wb_i = 0; bus4.aluout_wb_i = 0;
        bus4.ext_wb_i = 0; bus4.rd_wb_i = 0; bus4.cd_wb_i = 0;
    endtask

    // Plain ALU-sourced GPR write presented on the WB fields.
    task automatic drive_wr(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_valid_i = 1; bus.reg_write_wb_i = 1; bus.first_wb_i = 0;
        bus.mem_to_reg_wb_i = MTR_ALU; bus.rd_wb_i = {27'd0, rd}; bus.aluout_wb_i = data;
        bus.md_wb_i = 32'hBAD0_0001; bus.npc_wb_i = 32'hBAD0_0002;
        bus.ext_wb_i = 32'hBAD0_0003; bus.cd_wb_i = 32'hBAD0_0004;
    endtask

    task automatic test_reset();
        rst = 1; set_idle(); ra1 = 5; ra2 = 0; dbg_addr = 5;
        ra1_4 = 0; ra2_4 = 0; dbg_addr_4 = 0;
        @(negedge clk);
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %h expected %h", instret, 32'd0); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg: got %h expected %h", dbg_data, 32'd0); end
        @(posedge clk); #1 rst = 0;
        drive_wr(5, 32'h1234);
        @(posedge clk); #1 set_idle();
        checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL pre_reset_r5: got %h expected %h", dbg_data, 32'h1234); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL pre_reset_instret: got %h expected %h", instret, 32'd1); end
        #1 rst = 1;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL async_reset_dbg: got %h expected %h", dbg_data, 32'd0); end
        checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL async_reset_rd1: got %h expected %h", rd1, 32'd0); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL async_reset_instret: got %h expected %h", instret, 32'd0); end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_src_mux();
        logic [1:0]  mtr_t [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        logic        fst_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_t [5] = '{32'hA, 32'hB, 32'h404, 32'h1234_0000, 32'hC0};
        dbg_addr = 3;
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid_i = 1; bus.reg_write_wb_i = 1; bus.rd_wb_i = 32'd3;
            bus.mem_to_reg_wb_i = mtr_t[i]; bus.first_wb_i = fst_t[i];
            bus.aluout_wb_i = 32'hA; bus.md_wb_i = 32'hB; bus.npc_wb_i = 32'h404;
            bus.ext_wb_i = 32'h1234_0000; bus.cd_wb_i = 32'hC0;
            @(negedge clk);
            checks++; if (bus.wb_wdata_o !== exp_t[i]) begin errors++; $display("FAIL src_wdata[%0d]: got %h expected %h", i, bus.wb_wdata_o, exp_t[i]); end
            @(posedge clk); #1 set_idle();
            checks++; if (dbg_data !== exp_t[i]) begin errors++; $display("FAIL src_r3[%0d]: got %h expected %h", i, dbg_data, exp_t[i]); end
        end
    endtask

    task automatic test_bypass();
        drive_wr(7, 32'h1111_1111);
        @(posedge clk); #1;
        drive_wr(7, 32'hDEAD_BEEF); ra1 = 7; ra2 = 7; dbg_addr = 7;
        @(negedge clk);
        checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF); end
        checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd2: got %h expected %h", rd2, 32'hDEAD_BEEF); end
        checks++; if (dbg_data !== 32'h1111_1111) begin errors++; $display("FAIL bypass_dbg_old: got %h expected %h", dbg_data, 32'h1111_1111); end
        @(posedge clk); #1 set_idle();
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_dbg_new: got %h expected %h", dbg_data, 32'hDEAD_BEEF); end
        checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL array_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    endtask

    task automatic test_zero_gate();
        drive_wr(0, 32'hFFFF_FFFF); ra1 = 0; dbg_addr = 0;
        @(negedge clk);
        checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL r0_rd1: got %h expected %h", rd1, 32'd0); end
        checks++; if (bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected %b", bus.wb_we_o, 1'b0); end
        checks++; if (bus.wb_wdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL r0_wdata_follow: got %h expected %h", bus.wb_wdata_o, 32'hFFFF_FFFF); end
        @(posedge clk); #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_dbg: got %h expected %h", dbg_data, 32'd0); end
        drive_wr(4, 32'h44); dbg_addr = 4; ra1 = 4;
        @(posedge clk); #1;
        // bubble, then non-writing instruction, both aimed at r4
        drive_wr(4, 32'h99); bus.wb_valid_i = 0;
        @(negedge clk);
        checks++; if (bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL bubble_we: got %b expected %b", bus.wb_we_o, 1'b0); end
        checks++; if (bus.wb_waddr_o !== 5'd4) begin errors++; $display("FAIL bubble_waddr: got %h expected %h", bus.wb_waddr_o, 5'd4); end
        checks++; if (rd1 !== 32'h44) begin errors++; $display("FAIL bubble_no_bypass: got %h expected %h", rd1, 32'h44); end
        @(posedge clk); #1;
        checks++; if (dbg_data !== 32'h44) begin errors++; $display("FAIL bubble_r4: got %h expected %h", dbg_data, 32'h44); end
        bus.wb_valid_i = 1; bus.reg_write_wb_i = 0;
        @(negedge clk);
        checks++; if (bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL norw_we: got %b expected %b", bus.wb_we_o, 1'b0); end
        @(posedge clk); #1 set_idle();
        checks++; if (dbg_data !== 32'h44) begin errors++; $display("FAIL norw_r4: got %h expected %h", dbg_data, 32'h44); end
    endtask

    task automatic test_counter();
        rst = 1; #1 rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) begin
            bus.wb_valid_i = (i != 2 && i != 6 && i != 11);
            bus.reg_write_wb_i = i[0];
            bus.rd_wb_i = 32'd0;
            @(posedge clk); #1;
        end
        set_idle();
        checks++; if (instret !== 32'd10) begin errors++; $display("FAIL instret_10: got %0d expected %0d", instret, 10); end
        checks++; if (instret_4 !== 4'd0) begin errors++; $display("FAIL instret4_idle: got %0d expected %0d", instret_4, 0); end
        bus4.wb_valid_i = 1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (instret_4 !== 4'd0) begin errors++; $display("FAIL instret4_wrap16: got %0d expected %0d", instret_4, 0); end
        @(posedge clk); #1 set_idle();
        checks++; if (instret_4 !== 4'd1) begin errors++; $display("FAIL instret4_17: got %0d expected %0d", instret_4, 1); end
        checks++; if (instret !== 32'd10) begin errors++; $display("FAIL instret_hold: got %0d expected %0d", instret, 10); end
    endtask

    task automatic test_reset_collision();
        dbg_addr = 9; ra1 = 9;
        drive_wr(9, 32'h55); rst = 1;
        @(negedge clk);
        checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL coll_rd1_in_reset: got %h expected %h", rd1, 32'd0); end
        checks++; if (bus.wb_we_o !== 1'b1) begin errors++; $display("FAIL coll_we_follows: got %b expected %b", bus.wb_we_o, 1'b1); end
        @(posedge clk); #1 set_idle(); rst = 0;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL coll_r9_lost: got %h expected %h", dbg_data, 32'd0); end
        drive_wr(9, 32'h66);
        @(posedge clk); #1 set_idle();
        checks++; if (dbg_data !== 32'h66) begin errors++; $display("FAIL coll_resume: got %h expected %h", dbg_data, 32'h66); end
    endtask

    initial begin
        test_reset();
        test_src_mux();
        test_bypass();
        test_zero_gate();
        test_counter();
        test_reset_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
